// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared types for the memory port arbiter:
//   - arb_state_e : arbiter FSM state encoding
//   - owner_e     : which pipeline stage owns the current transaction
//   - FETCH_BE    : byte enables used for every instruction fetch
//   - state_owner : maps an FSM state to the stage it serves
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;
    localparam logic [3:0]  FETCH_BE             = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE_IF = 3'd1,
        ST_ISSUE_DM = 3'd2,
        ST_WAIT_IF  = 3'd3,
        ST_WAIT_DM  = 3'd4
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    // Data-side states belong to MEM; everything else (including IDLE,
    // where no mem* output is driven anyway) maps to IF.
    function automatic owner_e state_owner(input arb_state_e st);
        owner_e own;
        case (st)
            ST_ISSUE_DM: own = OWN_DM;
            ST_WAIT_DM:  own = OWN_DM;
            default:     own = OWN_IF;
        endcase
        return own;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles every signal around the shared memory port:
//   fetch side : ifReq, ifAddr, ifFlush -> ifRdata, ifValid
//   data side  : dmReq, dmWe, dmAddr, dmWdata, dmBe -> dmRdata, dmValid
//   memory     : memReq, memWe, memAddr, memWdata, memBe <- memReady,
//                memRdata, memRvalid
//   stalls     : StallFMem, StallMMem
// Modports:
//   slave  : the arbiter (serves pipeline requests, drives the memory bus)
//   master : the environment (pipeline stages and memory model)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;

    logic        ifReq;
    logic [31:0] ifAddr;
    logic        ifFlush;
    logic [31:0] ifRdata;
    logic        ifValid;

    logic        dmReq;
    logic        dmWe;
    logic [31:0] dmAddr;
    logic [31:0] dmWdata;
    logic [3:0]  dmBe;
    logic [31:0] dmRdata;
    logic        dmValid;

    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memBe;
    logic        memReady;
    logic [31:0] memRdata;
    logic        memRvalid;

    logic        StallFMem;
    logic        StallMMem;

    modport slave (
        input  ifReq, ifAddr, ifFlush,
        output ifRdata, ifValid,
        input  dmReq, dmWe, dmAddr, dmWdata, dmBe,
        output dmRdata, dmValid,
        output memReq, memWe, memAddr, memWdata, memBe,
        input  memReady, memRdata, memRvalid,
        output StallFMem, StallMMem
    );

    modport master (
        output ifReq, ifAddr, ifFlush,
        input  ifRdata, ifValid,
        output dmReq, dmWe, dmAddr, dmWdata, dmBe,
        input  dmRdata, dmValid,
        input  memReq, memWe, memAddr, memWdata, memBe,
        output memReady, memRdata, memRvalid,
        input  StallFMem, StallMMem
    );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_starve_counter
// Saturating counter of consecutive data grants taken while a fetch waits.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   inc        : count one more data grant (saturates at LIMIT)
//   clr        : restart the streak (wins over inc)
//   at_limit   : registered flag, high while the count equals LIMIT
// -----------------------------------------------------------------------------
module mem_port_arbiter_starve_counter #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int unsigned CW    = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIM_C = CW'(LIMIT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          at_limit_q;
    logic          at_limit_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {CW{1'b0}};
        end else if (inc && (count_q != LIM_C)) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
        at_limit_d = (count_d == LIM_C);
    end

    // Counter and limit flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= {CW{1'b0}};
            at_limit_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            at_limit_q <= at_limit_d;
        end
    end

    assign at_limit = at_limit_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between instruction fetch (IF) and data memory (MEM).
// One transaction at a time: IDLE -> ISSUE_x (memReq high until memReady)
// -> WAIT_x (until memRvalid) -> IDLE. Data wins ties unless STARVE_LIMIT
// consecutive data grants have already been made while a fetch waited.
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   bus      : mem_port_arbiter_if.slave (pipeline, memory and stall signals)
// Parameter:
//   STARVE_LIMIT : data grants allowed in a row while a fetch waits (>= 1)
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     bus
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       drop_q;
    logic       drop_d;
    logic       grant_if_s;
    logic       grant_dm_s;
    logic       at_limit_s;
    logic       streak_inc_s;
    logic       streak_clr_s;
    owner_e     owner_s;
    logic       if_valid_s;
    logic       dm_valid_s;

    // Next-state, grant decisions and flush bookkeeping.
    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        grant_if_s = 1'b0;
        grant_dm_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A waiting fetch that hit the starvation limit beats data.
                if (bus.dmReq && !(bus.ifReq && at_limit_s)) begin
                    state_d    = ST_ISSUE_DM;
                    grant_dm_s = 1'b1;
                end else if (bus.ifReq) begin
                    state_d    = ST_ISSUE_IF;
                    grant_if_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE_IF: begin
                // A flushed fetch is still issued; only its response is dropped.
                if (bus.ifFlush) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
                if (bus.memReady) begin
                    state_d = ST_WAIT_IF;
                end else begin
                    state_d = ST_ISSUE_IF;
                end
            end
            ST_WAIT_IF: begin
                if (bus.memRvalid) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                end else if (bus.ifFlush) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
            end
            ST_ISSUE_DM: begin
                if (bus.memReady) begin
                    state_d = ST_WAIT_DM;
                end else begin
                    state_d = ST_ISSUE_DM;
                end
            end
            ST_WAIT_DM: begin
                if (bus.memRvalid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_DM;
                end
            end
            default: begin
                state_d = ST_IDLE;
                drop_d  = 1'b0;
            end
        endcase
    end

    // State and drop flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    // A data grant extends the streak only if a fetch is being passed over.
    assign streak_inc_s = grant_dm_s & bus.ifReq;
    assign streak_clr_s = grant_if_s | (grant_dm_s & ~bus.ifReq);

    mem_port_arbiter_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_counter (
        .clk      (clk),
        .rst      (rst),
        .inc      (streak_inc_s),
        .clr      (streak_clr_s),
        .at_limit (at_limit_s)
    );

    assign owner_s = state_owner(state_q);

    // Memory request mux, response routing and stall generation.
    always_comb begin
        bus.memReq   = 1'b0;
        bus.memWe    = 1'b0;
        bus.memAddr  = 32'h0000_0000;
        bus.memWdata = 32'h0000_0000;
        bus.memBe    = 4'h0;
        if ((state_q == ST_ISSUE_IF) || (state_q == ST_ISSUE_DM)) begin
            bus.memReq = 1'b1;
            case (owner_s)
                OWN_DM: begin
                    bus.memWe    = bus.dmWe;
                    bus.memAddr  = bus.dmAddr;
                    bus.memWdata = bus.dmWdata;
                    bus.memBe    = bus.dmBe;
                end
                default: begin
                    bus.memWe    = 1'b0;
                    bus.memAddr  = bus.ifAddr;
                    bus.memWdata = 32'h0000_0000;
                    bus.memBe    = FETCH_BE;
                end
            endcase
        end else begin
            bus.memReq = 1'b0;
        end

        // A flush arriving together with the response also discards it.
        if_valid_s = (state_q == ST_WAIT_IF) && bus.memRvalid &&
                     !(drop_q || bus.ifFlush);
        dm_valid_s = (state_q == ST_WAIT_DM) && bus.memRvalid;

        bus.ifValid   = if_valid_s;
        bus.dmValid   = dm_valid_s;
        bus.ifRdata   = if_valid_s ? bus.memRdata : 32'h0000_0000;
        bus.dmRdata   = dm_valid_s ? bus.memRdata : 32'h0000_0000;
        bus.StallFMem = bus.ifReq & ~if_valid_s;
        bus.StallMMem = bus.dmReq & ~dm_valid_s;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared memory port between the instruction-fetch (IF) and data-memory (MEM) stages of the RISC-V pipeline. It runs one transaction at a time through a small state machine and returns responses to the owning stage. It raises stall requests that are OR-ed into the pipeline stall/flush network next to the hazard unit. Data requests have priority over fetch requests, and a starvation counter guarantees that fetch still makes progress.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch waits (≥1)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- ifReq  in  1  fetch request; held by IF until ifValid
- ifAddr  in  32  fetch address; stable while ifReq is high
- ifFlush  in  1  FlushD from the hazard unit; the outstanding fetch response is discarded
- ifRdata  out  32  fetch data; valid with ifValid
- ifValid  out  1  one-cycle fetch completion
- dmReq  in  1  load/store request; held until dmValid
- dmWe  in  1  1 = store
- dmAddr  in  32  data address
- dmWdata  in  32  store data
- dmBe  in  4  store byte enables
- dmRdata  out  32  load data; valid with dmValid
- dmValid  out  1  one-cycle load/store completion
- memReq, memWe  out  1  request to memory, write strobe
- memAddr, memWdata  out  32  memory address and write data
- memBe  out  4  byte enables
- memReady  in  1  memory accepts the request this cycle
- memRdata  in  32  read data
- memRvalid  in  1  response for the accepted request (writes also return one)
- StallFMem  out  1  freeze the PC and IF/ID registers
- StallMMem  out  1  freeze the whole pipeline (data access pending)

## Operation
- States: IDLE, ISSUE_IF, ISSUE_DM, WAIT_IF, WAIT_DM. Reset state is IDLE. streak = 0, drop = 0.
- IDLE: dmReq takes priority → ISSUE_DM, unless streak == STARVE_LIMIT and ifReq is high, in which case → ISSUE_IF. If only ifReq is high → ISSUE_IF. If there is no request, stay in IDLE.
- streak: increments on each DM grant while ifReq is high and saturates at STARVE_LIMIT. It clears on an IF grant, and also on a DM grant with ifReq low.
- ISSUE_x: memReq = 1, and the mem* outputs are muxed from owner x's live inputs. When memReady is high → WAIT_x. A fetch uses memWe = 0 and memBe = 4'hF.
- WAIT_x: memReq = 0. When memRvalid is high → IDLE and xValid = 1 for that cycle; xRdata = memRdata (combinational pass-through).
- Flush: ifFlush in ISSUE_IF or WAIT_IF sets drop. An IF response with drop set gives ifValid = 0 and clears drop. The transaction always completes on the memory side and is never abandoned.
- ifFlush in ISSUE_IF with memReady low: the request is still issued. IF re-presents its new address after the response.
- StallFMem = ifReq & ~ifValid. StallMMem = dmReq & ~dmValid. Both are combinational. StallMMem dominates, so when both are high the pipeline freezes entirely.
- Reset mid-transaction: the FSM returns to IDLE immediately. Any memory response arriving later in IDLE is ignored, so no xValid is raised.
- memRvalid outside WAIT_x is ignored.
- ifRdata/dmRdata are 0 when their valid is low.

## Timing
- Reset values: all outputs 0, except the data outputs, which are also 0. Outputs follow from the IDLE state.
- Minimum access: request cycle n → ISSUE at n+1 (memReq high). With memReady at n+1 → WAIT at n+2. With memRvalid at n+2 → xValid at n+2 and IDLE at n+3.
- Back-to-back grants: the next grant is decided in IDLE, one cycle after a completion, so the best-case throughput is one access per 3 cycles.
- Simultaneous ifReq and dmReq in IDLE: DM wins unless the starvation limit has been reached.
- Only one outstanding transaction at a time. memReq is never asserted in WAIT_x or IDLE.

## Structure
- Shared package (mem_pkg): the state encoding enum and the owner encoding (OWN_IF=0, OWN_DM=1).
- One natural sub-module: starve_counter, a saturating counter with clear, which produces the limit flag.
- The remaining logic (next-state, output mux, drop flag) lives in the top module.

## Test plan
- Single fetch: ifReq with addr 0x100, memReady immediate, memRvalid one cycle later with data 0xDEADBEEF → ifValid and ifRdata 0xDEADBEEF in the third cycle. StallFMem is high until then.
- Conflict: ifReq and dmReq rise together with store to 0x200, data 0x55, be 4'b0011 → memory first sees memWe=1, memAddr 0x200, memBe 0011, then the fetch.
- Starvation: ifReq held, dmReq re-asserted continuously, STARVE_LIMIT=4 → exactly 4 DM grants, then an IF grant, then DM resumes.
- Flush: ifFlush during WAIT_IF → memRvalid gives no ifValid. The next fetch's response is delivered normally.
- Wait states: memReady held low for 5 cycles in ISSUE_DM → memReq and dmAddr stay stable, StallMMem stays high, and no grant change occurs.
- Async reset in WAIT_DM → state is IDLE at once and all outputs are 0. A late memRvalid produces no dmValid.
